// File: rtl/ips2l_pcie_dma_pkg.sv
// Shared types for the PCIe DMA BAR write arbiter.
// State encoding, write source tags and counter width.
package ips2l_pcie_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic SRC_MWR  = 1'b0;
  localparam logic SRC_CPLD = 1'b1;
  localparam int   CNT_W    = 32;

endpackage

// File: rtl/ips2l_pcie_dma_bar_wr_arb_if.sv
// Requester beats in, registered BAR RAM write port out.
// master = requesters + RAM sink, slave = arbiter.
interface ips2l_pcie_dma_bar_wr_arb_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 128
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  i_req0_vld;
  logic                  o_req0_rdy;
  logic                  i_req0_last;
  logic [ADDR_WIDTH-1:0] i_req0_addr;
  logic [DATA_WIDTH-1:0] i_req0_data;
  logic [BE_W-1:0]       i_req0_be;

  logic                  i_req1_vld;
  logic                  o_req1_rdy;
  logic                  i_req1_last;
  logic [ADDR_WIDTH-1:0] i_req1_addr;
  logic [DATA_WIDTH-1:0] i_req1_data;
  logic [BE_W-1:0]       i_req1_be;

  logic                  o_ram_wr_en;
  logic [ADDR_WIDTH-1:0] o_ram_wr_addr;
  logic [DATA_WIDTH-1:0] o_ram_wr_data;
  logic [BE_W-1:0]       o_ram_wr_byte_en;
  logic                  o_ram_wr_src;
  logic                  o_busy;

  modport master (
    output i_req0_vld, i_req0_last, i_req0_addr,
    output i_req0_data, i_req0_be,
    output i_req1_vld, i_req1_last, i_req1_addr,
    output i_req1_data, i_req1_be,
    input  o_req0_rdy, o_req1_rdy,
    input  o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data,
    input  o_ram_wr_byte_en, o_ram_wr_src, o_busy
  );

  modport slave (
    input  i_req0_vld, i_req0_last, i_req0_addr,
    input  i_req0_data, i_req0_be,
    input  i_req1_vld, i_req1_last, i_req1_addr,
    input  i_req1_data, i_req1_be,
    output o_req0_rdy, o_req1_rdy,
    output o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data,
    output o_ram_wr_byte_en, o_ram_wr_src, o_busy
  );

endinterface

// File: rtl/ips2l_pcie_dma_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module ips2l_pcie_dma_sat_cnt
  import ips2l_pcie_dma_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)
      cnt_d = '0;
    else if (i_inc && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/ips2l_pcie_dma_bar_wr_arb.sv
// Burst-granular round-robin arbiter for the BAR RAM write port.
// IPS2L_PCIE_DMA_ARB_CNT_EN adds per-source beat counters.
module ips2l_pcie_dma_bar_wr_arb
  import ips2l_pcie_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 128
) (
  input  logic clk,
  input  logic rst,
`ifdef IPS2L_PCIE_DMA_ARB_CNT_EN
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_req0_wr_cnt,
  output logic [CNT_W-1:0] o_req1_wr_cnt,
`endif
  ips2l_pcie_dma_bar_wr_arb_if.slave bus
);

  localparam int BE_W = DATA_WIDTH / 8;

  arb_state_e            state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  rdy0_q, rdy0_d;
  logic                  rdy1_q, rdy1_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic                  src_q, src_d;
  logic                  acc0, acc1;

  assign acc0 = rdy0_q & bus.i_req0_vld;
  assign acc1 = rdy1_q & bus.i_req1_vld;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_req0_vld && bus.i_req1_vld)
          state_d = rr_q ? GNT1 : GNT0;
        else if (bus.i_req0_vld)
          state_d = GNT0;
        else if (bus.i_req1_vld)
          state_d = GNT1;
      end
      GNT0: begin
        if (acc0 && bus.i_req0_last) begin
          rr_d = 1'b1;
          if (bus.i_req1_vld)      state_d = GNT1;
          else if (bus.i_req0_vld) state_d = GNT0;
          else                     state_d = IDLE;
        end
      end
      GNT1: begin
        if (acc1 && bus.i_req1_last) begin
          rr_d = 1'b0;
          if (bus.i_req0_vld)      state_d = GNT0;
          else if (bus.i_req1_vld) state_d = GNT1;
          else                     state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready is a pure decode of the next state, so it is glitch-free
    rdy0_d = (state_d == GNT0);
    rdy1_d = (state_d == GNT1);
  end

  always_comb begin
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    src_d   = src_q;
    unique case (1'b1)
      acc0: begin
        wr_en_d = 1'b1;
        addr_d  = bus.i_req0_addr;
        data_d  = bus.i_req0_data;
        be_d    = bus.i_req0_be;
        src_d   = SRC_MWR;
      end
      acc1: begin
        wr_en_d = 1'b1;
        addr_d  = bus.i_req1_addr;
        data_d  = bus.i_req1_data;
        be_d    = bus.i_req1_be;
        src_d   = SRC_CPLD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      src_q   <= SRC_MWR;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      src_q   <= src_d;
    end
  end

  assign bus.o_req0_rdy       = rdy0_q;
  assign bus.o_req1_rdy       = rdy1_q;
  assign bus.o_ram_wr_en      = wr_en_q;
  assign bus.o_ram_wr_addr    = addr_q;
  assign bus.o_ram_wr_data    = data_q;
  assign bus.o_ram_wr_byte_en = be_q;
  assign bus.o_ram_wr_src     = src_q;
  assign bus.o_busy           = (state_q != IDLE);

`ifdef IPS2L_PCIE_DMA_ARB_CNT_EN
  ips2l_pcie_dma_sat_cnt u_cnt0 (
    .clk   (clk),
    .rst   (rst),
    .i_clr (i_cnt_clr),
    .i_inc (acc0),
    .o_cnt (o_req0_wr_cnt)
  );

  ips2l_pcie_dma_sat_cnt u_cnt1 (
    .clk   (clk),
    .rst   (rst),
    .i_clr (i_cnt_clr),
    .i_inc (acc1),
    .o_cnt (o_req1_wr_cnt)
  );
`endif

endmodule

// File: tb/tb_ips2l_pcie_dma_bar_wr_arb.sv
// Directed bench for the BAR write arbiter.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_ips2l_pcie_dma_bar_wr_arb;
  import ips2l_pcie_dma_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ips2l_pcie_dma_bar_wr_arb_if #(
    .ADDR_WIDTH (9),
    .DATA_WIDTH (128)
  ) bus ();

`ifdef IPS2L_PCIE_DMA_ARB_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [31:0] cnt0, cnt1;
`endif

  ips2l_pcie_dma_bar_wr_arb #(
    .ADDR_WIDTH (9),
    .DATA_WIDTH (128)
  ) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef IPS2L_PCIE_DMA_ARB_CNT_EN
    .i_cnt_clr     (cnt_clr),
    .o_req0_wr_cnt (cnt0),
    .o_req1_wr_cnt (cnt1),
`endif
    .bus           (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(logic [8:0] a);
    logic [7:0] b;
    b = a[7:0] ^ 8'h5a;
    return {16{b}};
  endfunction

  task automatic idle_all();
    bus.i_req0_vld  = 1'b0;
    bus.i_req0_last = 1'b0;
    bus.i_req0_addr = '0;
    bus.i_req0_data = '0;
    bus.i_req0_be   = '1;
    bus.i_req1_vld  = 1'b0;
    bus.i_req1_last = 1'b0;
    bus.i_req1_addr = '0;
    bus.i_req1_data = '0;
    bus.i_req1_be   = '1;
  endtask

  task automatic set0(logic v, logic [8:0] a, logic l, logic [15:0] be);
    bus.i_req0_vld  = v;
    bus.i_req0_addr = a;
    bus.i_req0_data = pat(a);
    bus.i_req0_last = l;
    bus.i_req0_be   = be;
  endtask

  task automatic set1(logic v, logic [8:0] a, logic l, logic [15:0] be);
    bus.i_req1_vld  = v;
    bus.i_req1_addr = a;
    bus.i_req1_data = pat(a);
    bus.i_req1_last = l;
    bus.i_req1_be   = be;
  endtask

  task automatic chk_wr(string tag, logic [8:0] a, logic s);
    chk({tag, "_en"}, 128'(bus.o_ram_wr_en), 128'(1'b1));
    chk({tag, "_addr"}, 128'(bus.o_ram_wr_addr), 128'(a));
    chk({tag, "_data"}, bus.o_ram_wr_data, pat(a));
    chk({tag, "_src"}, 128'(bus.o_ram_wr_src), 128'(s));
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle_all();
    tick();
    tick();
    rst = 1'b0;

    // Quiet after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_wr_en", 128'(bus.o_ram_wr_en), 128'(0));
      chk("idle_rdy", 128'({bus.o_req0_rdy, bus.o_req1_rdy}), 128'(0));
      chk("idle_busy", 128'(bus.o_busy), 128'(0));
    end
    chk("rst_addr", 128'(bus.o_ram_wr_addr), 128'(0));
    chk("rst_data", bus.o_ram_wr_data, 128'(0));
    chk("rst_be", 128'(bus.o_ram_wr_byte_en), 128'(0));
    chk("rst_src", 128'(bus.o_ram_wr_src), 128'(0));

    // req0 alone, 4 beats, beat 2 with be=0
    set0(1'b1, 9'h010, 1'b0, 16'hffff);
    chk("s2_rdy0_pre", 128'(bus.o_req0_rdy), 128'(0));
    tick();
    chk("s2_rdy0", 128'(bus.o_req0_rdy), 128'(1));
    chk("s2_rdy1", 128'(bus.o_req1_rdy), 128'(0));
    chk("s2_busy", 128'(bus.o_busy), 128'(1));
    chk("s2_noen", 128'(bus.o_ram_wr_en), 128'(0));
    for (int i = 0; i < 4; i++) begin
      set0(1'b1, 9'(9'h010 + i), (i == 3), (i == 2) ? 16'h0000 : 16'hffff);
      tick();
      chk_wr("s2_wr", 9'(9'h010 + i), SRC_MWR);
      chk("s2_be", 128'(bus.o_ram_wr_byte_en),
          (i == 2) ? 128'(0) : 128'(16'hffff));
    end
    set0(1'b0, 9'h1ff, 1'b0, 16'h1234);
    tick();
    chk("s2_hold_en", 128'(bus.o_ram_wr_en), 128'(0));
    chk("s2_hold_addr", 128'(bus.o_ram_wr_addr), 128'(9'h013));
    chk("s2_hold_be", 128'(bus.o_ram_wr_byte_en), 128'(16'hffff));

    // Contention: req0 first, then req1 with no bubble
    do_reset();
    set0(1'b1, 9'h020, 1'b0, 16'hffff);
    set1(1'b1, 9'h040, 1'b0, 16'hffff);
    tick();
    chk("s3_rdy0", 128'(bus.o_req0_rdy), 128'(1));
    chk("s3_rdy1", 128'(bus.o_req1_rdy), 128'(0));
    tick();
    chk_wr("s3_b0", 9'h020, SRC_MWR);
    set0(1'b1, 9'h021, 1'b1, 16'hffff);
    tick();
    chk_wr("s3_b1", 9'h021, SRC_MWR);
    chk("s3_sw_rdy1", 128'(bus.o_req1_rdy), 128'(1));
    chk("s3_sw_rdy0", 128'(bus.o_req0_rdy), 128'(0));
    set0(1'b0, 9'h000, 1'b0, 16'hffff);
    tick();
    chk_wr("s3_b2", 9'h040, SRC_CPLD);
    set1(1'b1, 9'h041, 1'b1, 16'hffff);
    set0(1'b1, 9'h022, 1'b1, 16'hffff);
    tick();
    chk_wr("s3_b3", 9'h041, SRC_CPLD);
    chk("s3_back_rdy0", 128'(bus.o_req0_rdy), 128'(1));
    set1(1'b0, 9'h000, 1'b0, 16'hffff);
    tick();
    chk_wr("s3_b4", 9'h022, SRC_MWR);

    // req1 stalls mid-burst while req0 waits
    do_reset();
    set1(1'b1, 9'h060, 1'b0, 16'hffff);
    tick();
    chk("s4_rdy1", 128'(bus.o_req1_rdy), 128'(1));
    set0(1'b1, 9'h030, 1'b1, 16'hffff);
    tick();
    chk_wr("s4_b0", 9'h060, SRC_CPLD);
    set1(1'b0, 9'h061, 1'b0, 16'hffff);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s4_stall_en", 128'(bus.o_ram_wr_en), 128'(0));
      chk("s4_stall_rdy0", 128'(bus.o_req0_rdy), 128'(0));
      chk("s4_stall_rdy1", 128'(bus.o_req1_rdy), 128'(1));
    end
    set1(1'b1, 9'h061, 1'b1, 16'hffff);
    tick();
    chk_wr("s4_b1", 9'h061, SRC_CPLD);
    chk("s4_rdy0", 128'(bus.o_req0_rdy), 128'(1));
    set1(1'b0, 9'h000, 1'b0, 16'hffff);
    tick();
    chk_wr("s4_b2", 9'h030, SRC_MWR);

    // Reset in the middle of a burst
    do_reset();
    set0(1'b1, 9'h050, 1'b0, 16'hffff);
    tick();
    tick();
    chk_wr("s5_b0", 9'h050, SRC_MWR);
    set0(1'b1, 9'h051, 1'b0, 16'hffff);
    tick();
    chk_wr("s5_b1", 9'h051, SRC_MWR);
    set0(1'b1, 9'h052, 1'b0, 16'hffff);
    rst = 1'b1;
    tick();
    chk("s5_en", 128'(bus.o_ram_wr_en), 128'(0));
    chk("s5_addr", 128'(bus.o_ram_wr_addr), 128'(0));
    chk("s5_data", bus.o_ram_wr_data, 128'(0));
    chk("s5_be", 128'(bus.o_ram_wr_byte_en), 128'(0));
    chk("s5_busy", 128'(bus.o_busy), 128'(0));
    chk("s5_rdy0", 128'(bus.o_req0_rdy), 128'(0));
    rst = 1'b0;
    idle_all();
    tick();

    // Single-beat burst from req1
    do_reset();
    set1(1'b1, 9'h0aa, 1'b1, 16'h00f0);
    tick();
    tick();
    chk_wr("s6_single", 9'h0aa, SRC_CPLD);
    chk("s6_be", 128'(bus.o_ram_wr_byte_en), 128'(16'h00f0));

`ifdef IPS2L_PCIE_DMA_ARB_CNT_EN
    do_reset();
    chk("cnt_rst0", 128'(cnt0), 128'(0));
    set0(1'b1, 9'h100, 1'b0, 16'hffff);
    tick();
    for (int i = 0; i < 5; i++) begin
      set0(1'b1, 9'(9'h100 + i), (i == 4), 16'hffff);
      if (i == 4) set1(1'b1, 9'h180, 1'b0, 16'hffff);
      tick();
    end
    set0(1'b0, 9'h000, 1'b0, 16'hffff);
    for (int i = 0; i < 3; i++) begin
      set1(1'b1, 9'(9'h180 + i), (i == 2), 16'hffff);
      tick();
    end
    chk("cnt0_5", 128'(cnt0), 128'(5));
    chk("cnt1_3", 128'(cnt1), 128'(3));
    set1(1'b1, 9'h190, 1'b1, 16'hffff);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt1_clr", 128'(cnt1), 128'(0));
    chk("cnt0_clr", 128'(cnt0), 128'(0));
    idle_all();
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ips2l_pcie_dma_bar_wr_arb.md
# ips2l_pcie_dma_bar_wr_arb

Round-robin, burst-granular arbiter that shares one BAR RAM write port between the MWr write path (requester 0) and the CplD write path (requester 1) in the PCIe DMA RX datapath. It sits between the write-control blocks and the dual-port BAR RAM. It grants whole write bursts (one TLP's worth of beats), so a TLP's writes are never interleaved, and it drives a registered RAM write port tagged with the winning source.

## Interface
- ADDR_WIDTH, 9, RAM word address width
- DATA_WIDTH, 128, RAM data width; byte-enable width is DATA_WIDTH/8
- clk  in  1  core clock (62.5/125 MHz)
- rst  in  1  synchronous, active-high reset
- i_req0_vld / i_req1_vld  in  1  beat valid from MWr / CplD path
- o_req0_rdy / o_req1_rdy  out  1  beat accepted when vld&rdy
- i_req0_last / i_req1_last  in  1  final beat of the burst
- i_req0_addr / i_req1_addr  in  ADDR_WIDTH  beat word address
- i_req0_data / i_req1_data  in  DATA_WIDTH  beat data
- i_req0_be / i_req1_be  in  DATA_WIDTH/8  beat byte enables
- o_ram_wr_en  out  1  RAM write strobe
- o_ram_wr_addr  out  ADDR_WIDTH
- o_ram_wr_data  out  DATA_WIDTH
- o_ram_wr_byte_en  out  DATA_WIDTH/8
- o_ram_wr_src  out  1  source of the current write (0=MWr, 1=CplD)
- o_busy  out  1  state != IDLE
- i_cnt_clr  in  1  clears counters (only with IPS2L_PCIE_DMA_ARB_CNT_EN)
- o_req0_wr_cnt / o_req1_wr_cnt  out  32  beats written per source (only with the macro)

## Operation
- FSM states: IDLE, GNT0, GNT1. rr_ptr (1 bit) names the preferred requester. Reset: IDLE, rr_ptr=0.
- IDLE: if only one vld is high, go to that GNTn. If both are high, go to GNT[rr_ptr]. If neither is high, stay. No beat is accepted in IDLE.
- GNTn: o_reqn_rdy=1 and the other rdy=0. rdy depends only on state (no combinational path from vld).
- On an accepted beat with last=1: set rr_ptr to the other requester. Next state is GNT(other) if the other vld is high, else GNTn if reqn vld is high (back-to-back burst), else IDLE.
- A beat with be=0 is still passed to the RAM unchanged.
- Registered output stage: on vld&rdy, capture the granted addr/data/be, set o_ram_wr_src=n and o_ram_wr_en=1. Otherwise o_ram_wr_en=0, and addr/data/be/src hold their previous values.
- No timeout. A granted requester owns the port until its last beat. A requester that stalls (vld low) mid-burst keeps the grant.

## Timing
- Reset values: o_ram_wr_en=0, addr/data/be=0, o_ram_wr_src=0, both rdy=0, o_busy=0, counters=0.
- Arbitration latency: 1 cycle from first vld in IDLE to rdy high.
- Write latency: the accepted beat appears on the RAM port on the next clock edge.
- Throughput: 1 beat/cycle within a burst. Switching between requesters at a last beat adds 0 bubble cycles.
- Simultaneous first requests: the rr_ptr owner wins. The loser's vld must stay high; its beat is held, not dropped.
- Reset asserted mid-burst: the FSM returns to IDLE on the next edge and the burst is abandoned. The requesters share rst and restart.
- Single-beat burst (vld&last in the same beat): handled as a complete burst.

## Configuration
- IPS2L_PCIE_DMA_ARB_CNT_EN defined: two 32-bit counters each increment on an accepted beat of their source and saturate at 0xFFFF_FFFF. i_cnt_clr has priority over increment. The counters feed the DMA check/debug path.
- Undefined: the counter ports are absent and i_cnt_clr is absent. The arbitration behaviour is unchanged.

## Structure
- Shared package ips2l_pcie_dma_pkg holds: the FSM state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2), the SRC_MWR/SRC_CPLD constants and the counter width (32).
- One sub-module: ips2l_pcie_dma_sat_cnt (saturating counter with clear), instantiated twice under the macro.
- FSM, rr_ptr and the output register stage live in the top module.

## Test plan
- Reset release with no requests -> o_ram_wr_en=0, rdy=0/0, o_busy=0 for 10 cycles.
- req0 4-beat burst alone, addrs 0x010..0x013 -> rdy0 high 1 cycle after vld. RAM writes 0x010..0x013 on consecutive cycles with src=0.
- Both vld in the same cycle after reset, each a 2-beat burst -> req0 served first, then req1 with no bubble. The next contention goes to req0 (rr_ptr returns to 0).
- req1 burst with vld low for 3 cycles mid-burst while req0 is waiting -> req1 keeps the grant and req0 rdy stays 0 until req1's last beat.
- rst asserted on beat 2 of a 4-beat req0 burst -> next cycle state IDLE, o_ram_wr_en=0, output regs=0.
- With the macro defined: 5 req0 beats and 3 req1 beats -> counters read 5/3. Pulse i_cnt_clr concurrent with a beat -> counter reads 0.
